// File: rtl/sobel_window.sv
// -----------------------------------------------------------------------------
// sobel_window
// Builds a sliding 3x3 pixel window over a raster-scanned frame using two line
// buffers and three 3-tap shift registers. Pixel values are passed unmodified.
//
// Parameters:
//   DW - pixel width in bits
//   W  - pixels per line (3..4096)
//   H  - lines per frame (3..4096)
//
// Ports:
//   clk        single clock, all state updates on posedge
//   rst        synchronous active-high reset, priority over in_valid
//   in_valid   in_data carries a pixel this cycle (always accepted)
//   in_data    pixel, raster order
//   in_sof     (only with SOBEL_WINDOW_SOF_EN) forces this pixel to (0,0)
//   out_valid  out_win holds a complete window this cycle
//   out_win    taps w0..w8, w0 in bits [DW-1:0], w8 in the top DW bits
//   out_eol    last window of the line (qualified by out_valid)
//   out_eof    last window of the frame (qualified by out_valid)
//
// Optional feature macro: SOBEL_WINDOW_SOF_EN
// -----------------------------------------------------------------------------
module sobel_window #(
  parameter int DW = 16,
  parameter int W  = 640,
  parameter int H  = 480
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
`ifdef SOBEL_WINDOW_SOF_EN
  input  logic            in_sof,
`endif
  output logic            out_valid,
  output logic [9*DW-1:0] out_win,
  output logic            out_eol,
  output logic            out_eof
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;

  // lb1 holds line r-1, lb2 holds line r-2 (relative to the incoming line)
  logic [DW-1:0] lb1_q [W];
  logic [DW-1:0] lb2_q [W];
  logic [DW-1:0] lb1_rd, lb2_rd;

  logic [DW-1:0] taps_q [9];
  logic [DW-1:0] taps_d [9];

  logic valid_q, valid_d;
  logic eol_q, eol_d;
  logic eof_q, eof_d;

  always_comb begin
    col_cur = col_q;
    row_cur = row_q;
`ifdef SOBEL_WINDOW_SOF_EN
    // A start-of-frame pixel is placed at (0,0); since no window is emitted
    // before row 2 col 2 of the new frame, nothing from the old frame leaks.
    if (in_valid && in_sof) begin
      col_cur = '0;
      row_cur = '0;
    end
`endif

    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_cur == CW'(W-1)) begin
        col_d = '0;
        row_d = (row_cur == RW'(H-1)) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end

    lb1_rd = lb1_q[col_cur];
    lb2_rd = lb2_q[col_cur];

    taps_d = taps_q;
    if (in_valid) begin
      taps_d[0] = taps_q[1];
      taps_d[1] = taps_q[2];
      taps_d[2] = lb2_rd;
      taps_d[3] = taps_q[4];
      taps_d[4] = taps_q[5];
      taps_d[5] = lb1_rd;
      taps_d[6] = taps_q[7];
      taps_d[7] = taps_q[8];
      taps_d[8] = in_data;
    end

    valid_d = in_valid && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
    eol_d   = valid_d && (col_cur == CW'(W-1));
    eof_d   = eol_d && (row_cur == RW'(H-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) taps_q[i] <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      taps_q  <= taps_d;
    end
  end

  // Line buffers are not reset; their stale contents never reach a valid window.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lb2_q[col_cur] <= lb1_rd;
      lb1_q[col_cur] <= in_data;
    end
  end

  always_comb begin
    out_win = '0;
    for (int unsigned i = 0; i < 9; i++) out_win[i*DW +: DW] = taps_q[i];
  end

  assign out_valid = valid_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;

endmodule

// File: tb/tb_sobel_window.sv
module tb_sobel_window;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
`ifdef SOBEL_WINDOW_SOF_EN
  logic            in_sof = 1'b0;
`endif
  logic            out_valid;
  logic [9*DW-1:0] out_win;
  logic            out_eol;
  logic            out_eof;

  sobel_window #(.DW(DW), .W(W), .H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef SOBEL_WINDOW_SOF_EN
    .in_sof    (in_sof),
`endif
    .out_valid (out_valid),
    .out_win   (out_win),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  typedef struct {
    logic [9*DW-1:0] win;
    logic            eol;
    logic            eof;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            wcnt = 0;
  logic          pend = 1'b0;
  logic          mon_en = 1'b0;
  logic [DW-1:0] img [H][W];
  int            pos = 0;

  task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: image stored as a 2-D array indexed by raster position.
  task automatic send(input logic v, input logic [DW-1:0] d, input logic r, input logic sof);
    int rr, cc;
    exp_t e;
    rst = r;
    in_valid = v;
    in_data = d;
`ifdef SOBEL_WINDOW_SOF_EN
    in_sof = sof;
`endif
    @(posedge clk);
    pend = 1'b0;
    if (r) begin
      pos = 0;
    end else if (v) begin
      if (sof) pos = 0;
      rr = pos / W;
      cc = pos % W;
      img[rr][cc] = d;
      if (rr >= 2 && cc >= 2) begin
        for (int k = 0; k < 3; k++) begin
          e.win[(0+k)*DW +: DW] = img[rr-2][cc-2+k];
          e.win[(3+k)*DW +: DW] = img[rr-1][cc-2+k];
          e.win[(6+k)*DW +: DW] = img[rr][cc-2+k];
        end
        e.eol = (cc == W-1);
        e.eof = (cc == W-1) && (rr == H-1);
        sb.push_back(e);
        pend = 1'b1;
      end
      pos = (pos + 1) % (W*H);
    end
    #1;
  endtask

  task automatic frame(input int base, input bit gaps);
    for (int i = 0; i < W*H; i++) begin
      send(1'b1, DW'(base + i), 1'b0, 1'b0);
      if (gaps) send(1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: compares presented windows against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("out_valid", {{(9*DW-1){1'b0}}, out_valid}, {{(9*DW-1){1'b0}}, pend});
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_window: got %h expected none", out_win);
          end else begin
            e = sb.pop_front();
            wcnt++;
            chk("out_win", out_win, e.win);
            chk("out_eol_eof", {{(9*DW-2){1'b0}}, out_eol, out_eof},
                {{(9*DW-2){1'b0}}, e.eol, e.eof});
          end
        end else begin
          chk("eol_eof_idle", {{(9*DW-2){1'b0}}, out_eol, out_eof}, '0);
        end
      end
    end
  end

  initial begin
    logic [9*DW-1:0] w_first;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = '0;

    send(1'b1, 16'hBEEF, 1'b1, 1'b0);
    mon_en = 1'b1;
    chk("reset_out_win", out_win, '0);
    chk("reset_flags", {{(9*DW-3){1'b0}}, out_valid, out_eol, out_eof}, '0);

    // Continuous frame 0..15 with an explicit spot check of the first window.
    wcnt = 0;
    for (int i = 0; i < W*H; i++) begin
      send(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 10) begin
        w_first = {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0};
        chk("first_window_const", out_win, w_first);
      end
    end
    send(1'b0, '0, 1'b0, 1'b0);
    chk("windows_frame1", 144'(wcnt), 144'(4));

    // Same frame with idle cycles interleaved.
    wcnt = 0;
    frame(0, 1'b1);
    chk("windows_gapped", 144'(wcnt), 144'(4));

    // Two back-to-back frames.
    wcnt = 0;
    frame(0, 1'b0);
    frame(100, 1'b0);
    send(1'b0, '0, 1'b0, 1'b0);
    chk("windows_two_frames", 144'(wcnt), 144'(8));

    // Reset mid-frame after pixel 6, with a pixel presented in the reset cycle.
    for (int i = 0; i <= 6; i++) send(1'b1, DW'(i), 1'b0, 1'b0);
    send(1'b1, 16'h7777, 1'b1, 1'b0);
    wcnt = 0;
    frame(0, 1'b0);
    send(1'b0, '0, 1'b0, 1'b0);
    chk("windows_after_reset", 144'(wcnt), 144'(4));

`ifdef SOBEL_WINDOW_SOF_EN
    for (int i = 0; i < 7; i++) send(1'b1, DW'(50 + i), 1'b0, 1'b0);
    wcnt = 0;
    send(1'b1, DW'(0), 1'b0, 1'b1);
    for (int i = 1; i < W*H; i++) send(1'b1, DW'(i), 1'b0, 1'b0);
    send(1'b0, '0, 1'b0, 1'b0);
    chk("windows_after_sof", 144'(wcnt), 144'(4));
`endif

    // Randomized traffic with occasional resets (and restarts when enabled).
    for (int n = 0; n < 3000; n++) begin
      logic v, r, s;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 399) == 0);
`ifdef SOBEL_WINDOW_SOF_EN
      s = ($urandom_range(0, 149) == 0);
`else
      s = 1'b0;
`endif
      send(v, DW'($urandom), r, s);
    end

    send(1'b0, '0, 1'b0, 1'b0);
    send(1'b0, '0, 1'b0, 1'b0);
    chk("scoreboard_empty", 144'(sb.size()), '0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
